// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and constants for the SRAM port-0 arbiter.
//   SRAM_RSP_LAT : cycles from handshake to response strobe
//   req_id_e     : requester identity (fetch = 0, LSU = 1)
//   tag_t        : per-stage in-flight tag {valid, id, is_write}
package sram_ctrl_pkg;

  localparam int unsigned SRAM_RSP_LAT = 3;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_LSU   = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
    logic    is_write;
  } tag_t;

endpackage

// File: rtl/sram_arb2.sv
// sram_arb2: two-way grant logic for the SRAM port-0 arbiter.
// Configuration macro: SRAM_ARB_RR_EN
//   defined   -> round-robin with a one-bit preferred-requester pointer
//   undefined -> fixed priority, requester 0 always wins (no state)
// Ports:
//   clk_i, rst_i : clock and synchronous active-high reset (RR build only)
//   valid_i[1:0] : per-requester request valid
//   gnt_o[1:0]   : one-hot grant (combinational), zero while rst_i is high
module sram_arb2 (
`ifdef SRAM_ARB_RR_EN
  input  logic       clk_i,
`endif
  input  logic       rst_i,
  input  logic [1:0] valid_i,
  output logic [1:0] gnt_o
);

`ifdef SRAM_ARB_RR_EN
  // ptr_q names the requester that wins a tie.
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = '0;
    if (!rst_i) begin
      if (valid_i[0] && (!valid_i[1] || !ptr_q)) gnt_o = 2'b01;
      else if (valid_i[1])                       gnt_o = 2'b10;
    end
  end

  // After any grant, prefer the requester that just lost out.
  always_comb begin
    ptr_d = ptr_q;
    if (|gnt_o) ptr_d = gnt_o[0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt_o = '0;
    if (!rst_i) begin
      gnt_o[0] = valid_i[0];
      gnt_o[1] = valid_i[1] && !valid_i[0];
    end
  end
`endif

endmodule

// File: rtl/sram_port0_arbiter.sv
// sram_port0_arbiter: arbitrates two requesters onto port 0 of the sram
// macro, drives the macro controls from registers and returns read data or
// a write acknowledgement a fixed SRAM_RSP_LAT cycles after the handshake.
// Configuration macro: SRAM_ARB_RR_EN (round-robin vs fixed priority).
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   req_valid_i / req_ready_o    : per-requester handshake (bit n = req n)
//   req_we_i, req_addr_i,
//   req_wdata_i, req_wmask_i     : per-requester fields, requester n in slice n
//   rsp_valid_o                  : per-requester one-cycle response strobe
//   rsp_rdata_o                  : shared read data (0 for write acks)
//   sram_csb0_o .. sram_din0_o   : registered macro port-0 controls
//   sram_dout0_i                 : macro port-0 read data
module sram_port0_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned NUM_WMASKS = DATA_WIDTH / 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [1:0]              req_valid_i,
  output logic [1:0]              req_ready_o,
  input  logic [1:0]              req_we_i,
  input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [2*DATA_WIDTH-1:0] req_wdata_i,
  input  logic [2*NUM_WMASKS-1:0] req_wmask_i,
  output logic [1:0]              rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    sram_csb0_o,
  output logic                    sram_web0_o,
  output logic [NUM_WMASKS-1:0]   sram_wmask0_o,
  output logic [ADDR_WIDTH-1:0]   sram_addr0_o,
  output logic [DATA_WIDTH-1:0]   sram_din0_o,
  input  logic [DATA_WIDTH-1:0]   sram_dout0_i
);

  logic [1:0]            gnt;
  logic                  acc;
  logic                  win;
  logic                  we_sel;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] wdata_sel;
  logic [NUM_WMASKS-1:0] wmask_sel;

  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  tag_t                  tag_q [SRAM_RSP_LAT];
  tag_t                  tag_d [SRAM_RSP_LAT];

  sram_arb2 u_arb (
`ifdef SRAM_ARB_RR_EN
    .clk_i   (clk_i),
`endif
    .rst_i   (rst_i),
    .valid_i (req_valid_i),
    .gnt_o   (gnt)
  );

  assign req_ready_o = gnt;
  assign acc         = |gnt;
  assign win         = gnt[1];

  assign we_sel    = win ? req_we_i[1] : req_we_i[0];
  assign addr_sel  = win ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr_i[ADDR_WIDTH-1:0];
  assign wdata_sel = win ? req_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata_i[DATA_WIDTH-1:0];
  assign wmask_sel = win ? req_wmask_i[2*NUM_WMASKS-1:NUM_WMASKS] : req_wmask_i[NUM_WMASKS-1:0];

  always_comb begin
    csb_d   = 1'b1;
    web_d   = 1'b1;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;
    tag_d[0] = '0;
    if (acc) begin
      csb_d   = 1'b0;
      web_d   = ~we_sel;
      wmask_d = we_sel ? wmask_sel : '0;
      addr_d  = addr_sel;
      din_d   = wdata_sel;
      tag_d[0].valid    = 1'b1;
      tag_d[0].id       = req_id_e'(win);
      tag_d[0].is_write = we_sel;
    end
    for (int unsigned i = 1; i < SRAM_RSP_LAT; i++) tag_d[i] = tag_q[i-1];
    // dout0 is valid during the stage holding the macro's negedge access,
    // one stage before the response stage.
    rdata_d = '0;
    if (tag_q[SRAM_RSP_LAT-2].valid && !tag_q[SRAM_RSP_LAT-2].is_write)
      rdata_d = sram_dout0_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      for (int unsigned i = 0; i < SRAM_RSP_LAT; i++) tag_q[i] <= '0;
    end else begin
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      for (int unsigned i = 0; i < SRAM_RSP_LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (tag_q[SRAM_RSP_LAT-1].valid) begin
      if (tag_q[SRAM_RSP_LAT-1].id == REQ_LSU) rsp_valid_o = 2'b10;
      else                                     rsp_valid_o = 2'b01;
    end
  end

  assign rsp_rdata_o   = rdata_q;
  assign sram_csb0_o   = csb_q;
  assign sram_web0_o   = web_q;
  assign sram_wmask0_o = wmask_q;
  assign sram_addr0_o  = addr_q;
  assign sram_din0_o   = din_q;

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// tb_sram_port0_arbiter: directed and random stimulus for sram_port0_arbiter
// with a behavioural sram macro and a transaction-level reference model.
// Honours SRAM_ARB_RR_EN for the expected arbitration policy.
module tb_sram_port0_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NM = 4;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [1:0]      req_we = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [2*NM-1:0] req_wmask = '0;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            csb, web;
  logic [NM-1:0]   wmask;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   din;
  logic [DW-1:0]   dout = '0;

  always #5 clk = ~clk;

  sram_port0_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .sram_csb0_o(csb), .sram_web0_o(web), .sram_wmask0_o(wmask),
    .sram_addr0_o(addr), .sram_din0_o(din), .sram_dout0_i(dout)
  );

  // Behavioural macro: captures controls at posedge, accesses at negedge.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          m_en = 1'b0, m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_din = '0;
  logic [NM-1:0] m_mask = '0;

  always @(posedge clk) begin
    m_en <= !csb; m_we <= !web; m_addr <= addr; m_din <= din; m_mask <= wmask;
  end
  always @(negedge clk) begin
    if (m_en) begin
      if (m_we) begin
        for (int b = 0; b < NM; b++) if (m_mask[b]) mem[m_addr][8*b +: 8] = m_din[8*b +: 8];
      end else begin
        dout = mem[m_addr];
      end
    end
  end

  // Reference model: memory updated in acceptance order, responses queued
  // with their due cycle.
  typedef struct { int due; int id; logic [DW-1:0] data; } exp_t;
  exp_t          pend [$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            pref = 1'b0;
  bit            last_acc = 1'b0, last_we = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_din = '0;
  logic [NM-1:0] last_mask = '0;
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  // Pending random requests per requester (held until granted).
  bit            hv [2];
  bit            hwe [2];
  logic [AW-1:0] ha [2];
  logic [DW-1:0] hd [2];
  logic [NM-1:0] hm [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic put(input int n, input bit v, input bit we, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [NM-1:0] m);
    req_valid[n]         = v;
    req_we[n]            = we;
    req_addr[n*AW +: AW] = a;
    req_wdata[n*DW +: DW] = d;
    req_wmask[n*NM +: NM] = m;
  endtask

  task automatic idle_inputs();
    put(0, 1'b0, 1'b0, '0, '0, '0);
    put(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // One clock: check everything at the negedge, then advance the model at
  // the posedge. Returns the expected grant.
  task automatic cycle(output logic [1:0] eg);
    int w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [NM-1:0] m;
    @(negedge clk);
    if (rst || req_valid == 2'b00) eg = 2'b00;
    else if (req_valid == 2'b11)   eg = (RR && pref) ? 2'b10 : 2'b01;
    else                           eg = req_valid;
    chk("ready", {62'd0, req_ready}, {62'd0, eg});
    if (pend.size() > 0 && pend[0].due == cyc) begin
      chk("rsp_valid", {62'd0, rsp_valid}, 64'(1 << pend[0].id));
      chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, pend[0].data});
      void'(pend.pop_front());
    end else begin
      chk("rsp_idle", {62'd0, rsp_valid}, 64'd0);
    end
    chk("csb", {63'd0, csb}, {63'd0, !last_acc});
    chk("web", {63'd0, web}, {63'd0, !(last_acc && last_we)});
    chk("addr", {54'd0, addr}, {54'd0, last_addr});
    chk("din", {32'd0, din}, {32'd0, last_din});
    if (last_acc) chk("wmask", {60'd0, wmask}, {60'd0, last_mask});
    @(posedge clk);
    cyc++;
    if (rst) begin
      pend.delete();
      pref = 1'b0; last_acc = 1'b0; last_we = 1'b0;
      last_addr = '0; last_din = '0; last_mask = '0;
    end else begin
      last_acc = (eg != 2'b00);
      if (last_acc) begin
        w = eg[1] ? 1 : 0;
        a = req_addr[w*AW +: AW];
        d = req_wdata[w*DW +: DW];
        m = req_wmask[w*NM +: NM];
        last_we = req_we[w]; last_addr = a; last_din = d;
        last_mask = last_we ? m : '0;
        if (last_we) begin
          for (int b = 0; b < NM; b++) if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
          pend.push_back('{due: cyc + 2, id: w, data: '0});
        end else begin
          pend.push_back('{due: cyc + 2, id: w, data: ref_mem[a]});
        end
        pref = (w == 0);
      end
    end
    #1;
  endtask

  initial begin
    logic [1:0] g;
    int n0, n1;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    mem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
    mem[32] = 32'hAAAAAAAA; ref_mem[32] = 32'hAAAAAAAA;

    // Reset state
    rst = 1'b1; idle_inputs();
    repeat (3) cycle(g);
    rst = 1'b0;
    cycle(g);

    // Single read of 0x010 by requester 0
    put(0, 1'b1, 1'b0, 10'h010, '0, '0);
    cycle(g);
    idle_inputs();
    repeat (4) cycle(g);

    // Masked write then read-after-write by requester 1
    put(1, 1'b1, 1'b1, 10'h020, 32'h11223344, 4'b0101);
    cycle(g);
    put(1, 1'b1, 1'b0, 10'h020, '0, '0);
    cycle(g);
    idle_inputs();
    repeat (4) cycle(g);

    // Contention: both valid for 4 cycles
    n0 = 0; n1 = 0;
    for (int i = 0; i < 4; i++) begin
      put(0, 1'b1, 1'b0, 10'(i), '0, '0);
      put(1, 1'b1, 1'b0, 10'(100 + i), '0, '0);
      cycle(g);
      if (req_ready[0]) n0++;
      if (req_ready[1]) n1++;
    end
    chk("contention_r0", 64'(n0), RR ? 64'd2 : 64'd4);
    chk("contention_r1", 64'(n1), RR ? 64'd2 : 64'd0);
    idle_inputs();
    repeat (4) cycle(g);

    // Idle
    repeat (5) cycle(g);

    // Reset mid-flight
    put(0, 1'b1, 1'b0, 10'h005, '0, '0);
    cycle(g);
    put(0, 1'b1, 1'b0, 10'h006, '0, '0);
    cycle(g);
    put(0, 1'b1, 1'b0, 10'h007, '0, '0);
    rst = 1'b1;
    cycle(g);
    rst = 1'b0; idle_inputs();
    repeat (5) cycle(g);

    // Streaming reads 0x000..0x00F
    for (int i = 0; i < 16; i++) begin
      put(0, 1'b1, 1'b0, 10'(i), '0, '0);
      cycle(g);
    end
    idle_inputs();
    repeat (4) cycle(g);

    // Random traffic; losers hold their request until granted
    for (int n = 0; n < 2; n++) hv[n] = 1'b0;
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!hv[n]) begin
          hv[n]  = ($urandom_range(0, 3) != 0);
          hwe[n] = $urandom_range(0, 1) == 1;
          ha[n]  = 10'($urandom_range(0, 31));
          hd[n]  = $urandom;
          hm[n]  = 4'($urandom_range(0, 15));
        end
        put(n, hv[n], hwe[n], ha[n], hd[n], hm[n]);
      end
      if ($urandom_range(0, 99) == 0) rst = 1'b1;
      cycle(g);
      rst = 1'b0;
      for (int n = 0; n < 2; n++) if (g[n]) hv[n] = 1'b0;
    end
    idle_inputs();
    repeat (5) cycle(g);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
